// File: rtl/fifo_data_packer.sv
// Packs NumBeats narrow valid/ready beats into one wide word and pushes it into a downstream FIFO.
// The accumulator keeps filling while a finished word waits on a full FIFO; only the completing beat stalls.
module fifo_data_packer #(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned NumBeats = 8,
  parameter int unsigned OutWidth = InWidth * NumBeats,
  parameter int unsigned CntWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                flush_i,
  input  logic [InWidth-1:0]  data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [OutWidth-1:0] data_o,
  output logic                push_o,
  input  logic                full_i,
  output logic [CntWidth-1:0] beat_cnt_o,
  output logic                busy_o
);

  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);
  localparam int unsigned         TopLsb   = (NumBeats - 1) * InWidth;

  logic [OutWidth-1:0] acc_q, acc_d;
  logic [OutWidth-1:0] out_q, out_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                out_vld_q, out_vld_d;
  logic                flush_pend_q, flush_pend_d;

  logic last_beat, out_free, accept;

  assign last_beat = (cnt_q == LastBeat);
  assign push_o    = out_vld_q & ~full_i & ~clr_i;
  assign out_free  = ~out_vld_q | push_o;
  assign ready_o   = ~flush_pend_q & (~last_beat | out_free);
  assign accept    = valid_i & ready_o;

  assign data_o     = out_q;
  assign beat_cnt_o = cnt_q;
  assign busy_o     = (cnt_q != '0) | out_vld_q | flush_pend_q;

  always_comb begin
    acc_d        = acc_q;
    out_d        = out_q;
    cnt_d        = cnt_q;
    out_vld_d    = out_vld_q & ~push_o;
    flush_pend_d = flush_pend_q | flush_i;

    if (accept) begin
      if (last_beat) begin
        // Top slot of acc_q is always zero, so only the new beat needs merging in.
        out_d                       = acc_q;
        out_d[TopLsb +: InWidth]    = data_i;
        out_vld_d                   = 1'b1;
        cnt_d                       = '0;
        acc_d                       = '0;
      end else begin
        for (int k = 0; k < NumBeats; k++) begin
          if (cnt_q == CntWidth'(k)) acc_d[k*InWidth +: InWidth] = data_i;
        end
        cnt_d = cnt_q + CntWidth'(1);
      end
    end

    // ready_o is low while pending, so no beat can race with the flush below.
    if (flush_pend_q) begin
      if (cnt_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (out_free) begin
        out_d        = acc_q;
        out_vld_d    = 1'b1;
        cnt_d        = '0;
        acc_d        = '0;
        flush_pend_d = 1'b0;
      end
    end

    if (clr_i) begin
      acc_d        = '0;
      cnt_d        = '0;
      out_vld_d    = 1'b0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_fifo_data_packer.sv
// Scoreboard bench for fifo_data_packer at InWidth=8, NumBeats=4.
module tb_fifo_data_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        push_o;
  logic        full_i = 1'b0;
  logic [1:0]  beat_cnt_o;
  logic        busy_o;

  fifo_data_packer #(.InWidth(8), .NumBeats(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .push_o(push_o), .full_i(full_i),
    .beat_cnt_o(beat_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  int n_stall = 0;
  int n_push = 0;
  int cyc = 0;
  int push_cyc_last = 0;
  int push_cyc_prev = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl_acc = '0;
  int          mdl_cnt = 0;

  task automatic model_accept(input logic [7:0] d);
    mdl_acc[mdl_cnt*8 +: 8] = d;
    mdl_cnt++;
    if (mdl_cnt == 4) begin
      exp_q.push_back(mdl_acc);
      mdl_acc = '0;
      mdl_cnt = 0;
    end
  endtask

  task automatic model_flush();
    if (mdl_cnt > 0) exp_q.push_back(mdl_acc);
    mdl_acc = '0;
    mdl_cnt = 0;
  endtask

  task automatic model_clear();
    mdl_acc = '0;
    mdl_cnt = 0;
    exp_q.delete();
  endtask

  // Push monitor: every push must match the oldest expected word and never happen while full.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_ni && push_o) begin
      logic [31:0] exp;
      n_push++;
      push_cyc_prev = push_cyc_last;
      push_cyc_last = cyc;
      if (full_i) begin
        n_total++;
        $display("FAIL push_while_full push_o=%b required 0", push_o);
      end
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_push data_o=%h required no push", data_o);
      end else begin
        exp = exp_q.pop_front();
        if (data_o !== exp) $display("FAIL push_data data_o=%h required %h", data_o, exp);
        else n_pass++;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int cycles;
    cycles = 0;
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk_i);
    while (!ready_o && cycles < 50) begin
      cycles++;
      n_stall++;
      @(negedge clk_i);
    end
    if (!ready_o) begin
      n_total++;
      $display("FAIL send_timeout beat=%h ready_o=%b required 1", d, ready_o);
    end else begin
      model_accept(d);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({ready_o, push_o, busy_o, beat_cnt_o, data_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0})
      $display("FAIL reset_values rdy=%b push=%b busy=%b cnt=%0d data=%h required 1 0 0 0 0",
               ready_o, push_o, busy_o, beat_cnt_o, data_o);
    else n_pass++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int stall0;
    stall0 = n_stall;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    @(negedge clk_i);
    n_total++;
    if (push_o !== 1'b1) $display("FAIL basic_latency push_o=%b required 1", push_o);
    else n_pass++;
    n_total++;
    if (n_stall != stall0) $display("FAIL basic_ready stalls=%0d required 0", n_stall - stall0);
    else n_pass++;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int stall0, push0;
    stall0 = n_stall;
    push0  = n_push;
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11));
    repeat (3) @(negedge clk_i);
    n_total++;
    if (n_push - push0 != 2) $display("FAIL b2b_push_count got=%0d required 2", n_push - push0);
    else n_pass++;
    n_total++;
    if (push_cyc_last - push_cyc_prev != 4)
      $display("FAIL b2b_push_spacing got=%0d required 4", push_cyc_last - push_cyc_prev);
    else n_pass++;
    n_total++;
    if (n_stall != stall0) $display("FAIL b2b_stall stalls=%0d required 0", n_stall - stall0);
    else n_pass++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_full();
    int stall0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    full_i = 1'b1;
    stall0 = n_stall;
    send(8'h55); send(8'h66); send(8'h77);
    n_total++;
    if (n_stall != stall0) $display("FAIL full_fill_stalls got=%0d required 0", n_stall - stall0);
    else n_pass++;
    valid_i = 1'b1;
    data_i  = 8'h88;
    @(negedge clk_i);
    n_total++;
    if ({ready_o, push_o} !== 2'b00) $display("FAIL full_stall ready/push=%b required 00", {ready_o, push_o});
    else n_pass++;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    full_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if (ready_o !== 1'b1) $display("FAIL full_release ready_o=%b required 1", ready_o);
    else n_pass++;
    model_accept(8'h88);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  task automatic test_flush();
    int push0;
    send(8'hAA); send(8'hBB);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    model_flush();
    @(negedge clk_i);
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL flush_pending_ready ready_o=%b required 0", ready_o);
    else n_pass++;
    @(negedge clk_i);
    n_total++;
    if ({push_o, beat_cnt_o} !== 3'b100) $display("FAIL flush_push push=%b cnt=%0d required 1 0", push_o, beat_cnt_o);
    else n_pass++;
    @(posedge clk_i); #1;
    push0 = n_push;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    repeat (4) @(negedge clk_i);
    n_total++;
    if (n_push != push0 || busy_o !== 1'b0)
      $display("FAIL flush_empty pushes=%0d busy=%b required 0 0", n_push - push0, busy_o);
    else n_pass++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_clear();
    full_i = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hA1); send(8'hA2);
    clr_i   = 1'b1;
    full_i  = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'hEE;
    @(negedge clk_i);
    n_total++;
    if (push_o !== 1'b0) $display("FAIL clear_push push_o=%b required 0", push_o);
    else n_pass++;
    model_clear();
    @(posedge clk_i); #1;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    n_total++;
    if ({busy_o, beat_cnt_o} !== 3'b000) $display("FAIL clear_state busy=%b cnt=%0d required 0 0", busy_o, beat_cnt_o);
    else n_pass++;
    @(posedge clk_i); #1;
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  task automatic test_async_reset();
    send(8'h5A); send(8'h6B);
    #2;
    rst_ni = 1'b0;
    #1;
    n_total++;
    if ({ready_o, push_o, busy_o, beat_cnt_o, data_o} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0})
      $display("FAIL async_reset rdy=%b push=%b busy=%b cnt=%0d data=%h required 1 0 0 0 0",
               ready_o, push_o, busy_o, beat_cnt_o, data_o);
    else n_pass++;
    model_clear();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    repeat (3) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full();
    test_flush();
    test_clear();
    test_async_reset();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain words_left=%0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
